rps_match_scorer: RTL and testbench

Downstream consumer of the stone-paper-scissors round arbiter. Accepts one 8-bit ASCII round result per handshake (0 tie, 49 P1, 50 P2, 63 invalid) and keeps per-player scores, a round count and an error count. Declares a match winner on first-to-WIN_TARGET and then holds the result until cleared. Its outputs drive the score display / LED stage.

---
 rtl/rps_match_scorer.sv | 167 ++++++++++++++++
 tb/tb_rps_match_scorer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rps_match_scorer.sv
//------------------------------------------------------------------------------
// Module      : rps_match_scorer
// Description : Match scorer for the stone-paper-scissors round arbiter.
//               Accepts one ASCII round result per valid/ready handshake
//               (0x00 tie, 0x31 P1, 0x32 P2, anything else invalid). It keeps
//               per-player scores, a round count and an error count. It
//               declares a winner on first-to-WIN_TARGET and then holds the
//               result until match_clear or reset.
// Optional    : `define DRAW_LIMIT_EN ends the match as a draw (winner 2'b11)
//               when the valid-round count reaches MAX_ROUNDS with no winner.
// Ports       : clk, rst_n (async, active low), ena (block enable)
//               result_code/result_valid/result_ready : result handshake
//               match_clear                           : synchronous restart
//               p1_score, p2_score, round_cnt, err_cnt, last_result,
//               match_over, match_winner              : display outputs
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rps_match_scorer #(
   parameter int WIN_TARGET = 3,
   parameter int SCORE_W    = 4,
   parameter int MAX_ROUNDS = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic [7:0]         result_code,
   input  logic               result_valid,
   output logic               result_ready,
   input  logic               match_clear,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [7:0]         round_cnt,
   output logic [3:0]         err_cnt,
   output logic [1:0]         last_result,
   output logic               match_over,
   output logic [1:0]         match_winner
);

   localparam logic [SCORE_W-1:0] c_WIN_SCORE = SCORE_W'(WIN_TARGET);

   // Elaboration-time parameter legality checks.
   if ((WIN_TARGET < 1) || (WIN_TARGET > (2**SCORE_W - 1))) begin : g_chk_win
      $error("rps_match_scorer: WIN_TARGET out of range");
   end
   if ((MAX_ROUNDS < 1) || (MAX_ROUNDS > 255)) begin : g_chk_max
      $error("rps_match_scorer: MAX_ROUNDS out of range");
   end

   typedef enum logic [0:0] {
      ST_PLAY = 1'b0,
      ST_DONE = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
   logic [SCORE_W-1:0] p1_inc, p2_inc;
   logic [7:0]         round_q, round_d, round_inc;
   logic [3:0]         err_q, err_d, err_inc;
   logic [1:0]         last_q, last_d;
   logic [1:0]         winner_q, winner_d;
   logic               accept;
   logic               player_win;

   assign result_ready = ena & (state_q == ST_PLAY);
   assign accept       = result_valid & result_ready;

   // Saturating increments; scores cannot wrap because reaching
   // WIN_TARGET ends the match.
   assign p1_inc    = p1_q + SCORE_W'(1);
   assign p2_inc    = p2_q + SCORE_W'(1);
   assign round_inc = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
   assign err_inc   = (err_q == 4'hF) ? err_q : err_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      p1_d       = p1_q;
      p2_d       = p2_q;
      round_d    = round_q;
      err_d      = err_q;
      last_d     = last_q;
      winner_d   = winner_q;
      player_win = 1'b0;

      // Clear outranks a same-cycle accept: that result is dropped.
      if (match_clear) begin
         state_d  = ST_PLAY;
         p1_d     = '0;
         p2_d     = '0;
         round_d  = '0;
         err_d    = '0;
         last_d   = 2'b00;
         winner_d = 2'b00;
      end else if (accept) begin
         case (result_code)
            8'h00: begin
               last_d  = 2'b00;
               round_d = round_inc;
            end
            8'h31: begin
               last_d  = 2'b01;
               round_d = round_inc;
               p1_d    = p1_inc;
               if (p1_inc == c_WIN_SCORE) begin
                  player_win = 1'b1;
                  winner_d   = 2'b01;
                  state_d    = ST_DONE;
               end
            end
            8'h32: begin
               last_d  = 2'b10;
               round_d = round_inc;
               p2_d    = p2_inc;
               if (p2_inc == c_WIN_SCORE) begin
                  player_win = 1'b1;
                  winner_d   = 2'b10;
                  state_d    = ST_DONE;
               end
            end
            default: begin
               last_d = 2'b11;
               err_d  = err_inc;
            end
         endcase
`ifdef DRAW_LIMIT_EN
         // Only a valid round can hit the limit; a win on that same round
         // takes precedence over the draw.
         if ((last_d != 2'b11) && !player_win && (round_d == 8'(MAX_ROUNDS))) begin
            winner_d = 2'b11;
            state_d  = ST_DONE;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_PLAY;
         p1_q     <= '0;
         p2_q     <= '0;
         round_q  <= '0;
         err_q    <= '0;
         last_q   <= 2'b00;
         winner_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         round_q  <= round_d;
         err_q    <= err_d;
         last_q   <= last_d;
         winner_q <= winner_d;
      end
   end

   assign p1_score     = p1_q;
   assign p2_score     = p2_q;
   assign round_cnt    = round_q;
   assign err_cnt      = err_q;
   assign last_result  = last_q;
   assign match_over   = (state_q == ST_DONE);
   assign match_winner = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_rps_match_scorer.sv
//------------------------------------------------------------------------------
// Module      : tb_rps_match_scorer
// Description : Scoreboard bench for rps_match_scorer. Directed steps push a
//               hand-computed expected output snapshot; an independent monitor
//               pops and compares after each clock edge or async reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rps_match_scorer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] result_code;
   logic       result_valid;
   logic       result_ready;
   logic       match_clear;
   logic [3:0] p1_score, p2_score;
   logic [7:0] round_cnt;
   logic [3:0] err_cnt;
   logic [1:0] last_result;
   logic       match_over;
   logic [1:0] match_winner;

   typedef struct {
      string      name;
      logic       rdy;
      logic [3:0] p1;
      logic [3:0] p2;
      logic [7:0] rc;
      logic [3:0] ec;
      logic [1:0] last;
      logic       over;
      logic [1:0] win;
   } snap_t;

   snap_t exp_q[$];
   int    n_pass  = 0;
   int    n_total = 0;

   rps_match_scorer #(
      .WIN_TARGET(3),
      .SCORE_W   (4),
      .MAX_ROUNDS(4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .result_code (result_code),
      .result_valid(result_valid),
      .result_ready(result_ready),
      .match_clear (match_clear),
      .p1_score    (p1_score),
      .p2_score    (p2_score),
      .round_cnt   (round_cnt),
      .err_cnt     (err_cnt),
      .last_result (last_result),
      .match_over  (match_over),
      .match_winner(match_winner)
   );

   always #5 clk = ~clk;

   function automatic snap_t mk(string nm, logic rdy, logic [3:0] p1, logic [3:0] p2,
                                logic [7:0] rc, logic [3:0] ec, logic [1:0] last,
                                logic over, logic [1:0] win);
      snap_t s;
      s.name = nm; s.rdy = rdy; s.p1 = p1; s.p2 = p2; s.rc = rc;
      s.ec = ec; s.last = last; s.over = over; s.win = win;
      return s;
   endfunction

   function automatic string fmt(snap_t s);
      return $sformatf("rdy=%b p1=%0d p2=%0d rc=%0d ec=%0d last=%b over=%b win=%b",
                       s.rdy, s.p1, s.p2, s.rc, s.ec, s.last, s.over, s.win);
   endfunction

   // Drive one cycle of inputs at the falling edge; after the rising edge
   // queue the outputs expected from it.
   task automatic step(input logic en, input logic v, input logic [7:0] code,
                       input logic clr, input snap_t e);
      @(negedge clk);
      ena          = en;
      result_valid = v;
      result_code  = code;
      match_clear  = clr;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
   endtask

   // Monitor: samples outputs 3 time units after each rising edge or
   // asynchronous reset assertion and checks the oldest expectation.
   initial begin
      snap_t e, g;
      forever begin
         @(posedge clk or negedge rst_n);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = mk(e.name, result_ready, p1_score, p2_score, round_cnt, err_cnt,
                   last_result, match_over, match_winner);
            n_total++;
            if ({g.rdy, g.p1, g.p2, g.rc, g.ec, g.last, g.over, g.win} ===
                {e.rdy, e.p1, e.p2, e.rc, e.ec, e.last, e.over, e.win})
               n_pass++;
            else
               $display("FAIL %s: got [%s] want [%s]", e.name, fmt(g), fmt(e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ena = 1'b1; result_valid = 1'b0; result_code = 8'h00;
      match_clear = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state.
      step(1, 0, 8'h00, 0, mk("reset",  1, 0, 0, 0, 0, 2'b00, 0, 2'b00));

      // P1 takes the match 3-1.
      step(1, 1, 8'h31, 0, mk("win_r1", 1, 1, 0, 1, 0, 2'b01, 0, 2'b00));
      step(1, 1, 8'h32, 0, mk("win_r2", 1, 1, 1, 2, 0, 2'b10, 0, 2'b00));
      step(1, 1, 8'h31, 0, mk("win_r3", 1, 2, 1, 3, 0, 2'b01, 0, 2'b00));
      step(1, 1, 8'h31, 0, mk("win_r4", 0, 3, 1, 4, 0, 2'b01, 1, 2'b01));

      // DONE ignores further results.
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 8'h32, 0, mk("done_hold", 0, 3, 1, 4, 0, 2'b01, 1, 2'b01));
         step(1, 0, 8'h00, 0, mk("done_idle", 0, 3, 1, 4, 0, 2'b01, 1, 2'b01));
      end
      step(1, 0, 8'h00, 1, mk("clear_done", 1, 0, 0, 0, 0, 2'b00, 0, 2'b00));

      // Level-held invalid code: err_cnt saturates at 15.
      for (int i = 0; i < 20; i++)
         step(1, 1, 8'h3F, 0, mk("err_sat", 1, 0, 0, 0, (i < 15) ? 4'(i + 1) : 4'd15,
                                 2'b11, 0, 2'b00));
      step(1, 1, 8'h7A, 0, mk("err_other", 1, 0, 0, 0, 15, 2'b11, 0, 2'b00));
      step(1, 0, 8'h00, 1, mk("clear_err", 1, 0, 0, 0, 0, 2'b00, 0, 2'b00));

      // Clear beats a simultaneous accept.
      step(1, 1, 8'h32, 0, mk("p2_a", 1, 0, 1, 1, 0, 2'b10, 0, 2'b00));
      step(1, 1, 8'h32, 0, mk("p2_b", 1, 0, 2, 2, 0, 2'b10, 0, 2'b00));
      step(1, 1, 8'h32, 1, mk("clr_prio", 1, 0, 0, 0, 0, 2'b00, 0, 2'b00));

      // ena low blocks the handshake.
      step(1, 1, 8'h31, 0, mk("p1_a", 1, 1, 0, 1, 0, 2'b01, 0, 2'b00));
      step(1, 1, 8'h31, 0, mk("p1_b", 1, 2, 0, 2, 0, 2'b01, 0, 2'b00));
      for (int i = 0; i < 4; i++)
         step(0, 1, 8'h31, 0, mk("ena_low", 0, 2, 0, 2, 0, 2'b01, 0, 2'b00));
      step(1, 0, 8'h00, 0, mk("ena_back", 1, 2, 0, 2, 0, 2'b01, 0, 2'b00));

      // Asynchronous reset between clock edges.
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.push_back(mk("async_rst", 1, 0, 0, 0, 0, 2'b00, 0, 2'b00));
      @(negedge clk);
      rst_n = 1'b1;

      // match_clear still acts while ena is low.
      step(1, 1, 8'h32, 0, mk("pre_clr", 1, 0, 1, 1, 0, 2'b10, 0, 2'b00));
      step(0, 0, 8'h00, 1, mk("clr_ena0", 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));

      // Draw limit (MAX_ROUNDS=4).
      step(1, 1, 8'h00, 0, mk("draw_r1", 1, 0, 0, 1, 0, 2'b00, 0, 2'b00));
      step(1, 1, 8'h31, 0, mk("draw_r2", 1, 1, 0, 2, 0, 2'b01, 0, 2'b00));
      step(1, 1, 8'h32, 0, mk("draw_r3", 1, 1, 1, 3, 0, 2'b10, 0, 2'b00));
`ifdef DRAW_LIMIT_EN
      step(1, 1, 8'h00, 0, mk("draw_r4", 0, 1, 1, 4, 0, 2'b00, 1, 2'b11));
`else
      step(1, 1, 8'h00, 0, mk("draw_r4", 1, 1, 1, 4, 0, 2'b00, 0, 2'b00));
`endif
      step(1, 0, 8'h00, 1, mk("clear_end", 1, 0, 0, 0, 0, 2'b00, 0, 2'b00));

      repeat (3) @(posedge clk);
      #5;
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
